// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction loader: the state encoding,
// the error reason codes and the default packet start marker.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HUNT = 3'd1,
    LEN  = 3'd2,
    DATA = 3'd3,
    CHK  = 3'd4,
    DONE = 3'd5,
    ERR  = 3'd6
  } state_t;

  localparam logic [1:0] ERR_FE  = 2'b00;
  localparam logic [1:0] ERR_LEN = 2'b01;
  localparam logic [1:0] ERR_CHK = 2'b10;
  localparam logic [1:0] ERR_TO  = 2'b11;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // States in which the CPU must be kept in reset.
  function automatic logic holds_cpu(input state_t st);
    logic hold;
    case (st)
      HUNT, LEN, DATA, CHK, ERR: hold = 1'b1;
      default:                   hold = 1'b0;
    endcase
    return hold;
  endfunction

  // States that lie inside a packet, where the idle-gap timer runs.
  function automatic logic in_packet(input state_t st);
    logic inside_pkt;
    case (st)
      LEN, DATA, CHK: inside_pkt = 1'b1;
      default:        inside_pkt = 1'b0;
    endcase
    return inside_pkt;
  endfunction

endpackage

// File: rtl/posedge_detection.sv
// Registered rising-edge detector: pulse is high for one cycle, one clock
// after sig is first sampled high.
module posedge_detection (
  input  logic Clk,
  input  logic Reset,
  input  logic sig,
  output logic pulse
);

  logic sig_d_r;

  // Remember the previous sample and flag a low-to-high transition.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sig_d_r <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      sig_d_r <= sig;
      pulse   <= sig & ~sig_d_r;
    end
  end

endmodule

// File: rtl/ins_loader.sv
// Program loader: recognises sync / length / payload / checksum packets from
// the UART receiver, writes the payload into instruction memory and keeps the
// CPU in reset while a load session is running.
module ins_loader
  import loader_pkg::*;
#(
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned ADDR_W      = 5,
  parameter logic [7:0]  SYNC_BYTE   = DEFAULT_SYNC_BYTE,
  parameter int unsigned TIMEOUT_CYC = 520600
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Load,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              rx_fe,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   byte_cnt
);

  localparam int unsigned       TO_W    = $clog2(TIMEOUT_CYC);
  localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [TO_W-1:0]   TO_ONE  = {{(TO_W-1){1'b0}}, 1'b1};
  localparam logic [7:0]        DEPTH_B = 8'(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_r, state_s;
  logic              load_rise_s;
  logic              rx_ok_s;
  logic              to_hit_s;
  logic              wr_s, enter_len_s, done_set_s, err_set_s;
  logic [1:0]        err_code_s;
  logic [ADDR_W:0]   len_r, len_s;
  logic [7:0]        sum_r, sum_s;
  logic [TO_W-1:0]   to_cnt_r, to_cnt_s;
  logic              session_start_s;
  logic              mem_we_s, cpu_hold_s, done_s, err_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [7:0]        mem_wdata_s;
  logic [1:0]        err_code_n_s;
  logic [ADDR_W:0]   byte_cnt_s;

  posedge_detection u_load_edge (
    .Clk   (Clk),
    .Reset (Reset),
    .sig   (Load),
    .pulse (load_rise_s)
  );

  // A framing error discards any byte arriving in the same cycle.
  assign rx_ok_s  = rx_valid & ~rx_fe;
  assign to_hit_s = (to_cnt_r == TO_LAST);

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decision plus the per-byte events that drive the datapath.
  always_comb begin
    state_s     = state_r;
    wr_s        = 1'b0;
    enter_len_s = 1'b0;
    done_set_s  = 1'b0;
    err_set_s   = 1'b0;
    err_code_s  = ERR_FE;
    if (!Load) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (load_rise_s) begin
            state_s = HUNT;
          end else begin
            state_s = IDLE;
          end
        end
        HUNT: begin
          if (rx_ok_s && (rx_data == SYNC_BYTE)) begin
            state_s     = LEN;
            enter_len_s = 1'b1;
          end else begin
            state_s = HUNT;
          end
        end
        LEN, DATA, CHK: begin
          if (rx_fe) begin
            state_s    = ERR;
            err_set_s  = 1'b1;
            err_code_s = ERR_FE;
          end else if (rx_valid) begin
            if (state_r == LEN) begin
              if ((rx_data == 8'd0) || (rx_data > DEPTH_B)) begin
                state_s    = ERR;
                err_set_s  = 1'b1;
                err_code_s = ERR_LEN;
              end else begin
                state_s = DATA;
              end
            end else if (state_r == DATA) begin
              wr_s = 1'b1;
              if ((byte_cnt_r_plus1()) == len_r) begin
                state_s = CHK;
              end else begin
                state_s = DATA;
              end
            end else begin
              if (rx_data == sum_r) begin
                state_s    = DONE;
                done_set_s = 1'b1;
              end else begin
                state_s    = ERR;
                err_set_s  = 1'b1;
                err_code_s = ERR_CHK;
              end
            end
          end else if (to_hit_s) begin
            state_s    = ERR;
            err_set_s  = 1'b1;
            err_code_s = ERR_TO;
          end else begin
            state_s = state_r;
          end
        end
        DONE, ERR: begin
          state_s = state_r;
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // Count of payload bytes including the one currently being accepted.
  function automatic logic [ADDR_W:0] byte_cnt_r_plus1();
    return byte_cnt + CNT_ONE;
  endfunction

  // Next values for the outputs and datapath registers.
  always_comb begin
    session_start_s = (state_r == IDLE) && (state_s == HUNT);
    mem_we_s        = wr_s;
    cpu_hold_s      = holds_cpu(state_s);
    if (wr_s) begin
      mem_addr_s  = byte_cnt[ADDR_W-1:0];
      mem_wdata_s = rx_data;
    end else begin
      mem_addr_s  = mem_addr;
      mem_wdata_s = mem_wdata;
    end
    if (session_start_s) begin
      done_s = 1'b0;
    end else if (done_set_s) begin
      done_s = 1'b1;
    end else begin
      done_s = done;
    end
    if (session_start_s) begin
      err_s        = 1'b0;
      err_code_n_s = err_code;
    end else if (err_set_s) begin
      err_s        = 1'b1;
      err_code_n_s = err_code_s;
    end else begin
      err_s        = err;
      err_code_n_s = err_code;
    end
    if (session_start_s) begin
      byte_cnt_s = {(ADDR_W+1){1'b0}};
    end else if (wr_s && (byte_cnt != DEPTH_C)) begin
      byte_cnt_s = byte_cnt + CNT_ONE;
    end else begin
      byte_cnt_s = byte_cnt;
    end
    if (enter_len_s) begin
      sum_s = 8'd0;
    end else if (wr_s) begin
      sum_s = sum_r + rx_data;
    end else begin
      sum_s = sum_r;
    end
    if ((state_r == LEN) && (state_s == DATA)) begin
      len_s = rx_data[ADDR_W:0];
    end else begin
      len_s = len_r;
    end
    if (in_packet(state_r) && !rx_valid) begin
      to_cnt_s = to_cnt_r + TO_ONE;
    end else begin
      to_cnt_s = {TO_W{1'b0}};
    end
  end

  // Output and datapath registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= {ADDR_W{1'b0}};
      mem_wdata <= 8'd0;
      cpu_hold  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_FE;
      byte_cnt  <= {(ADDR_W+1){1'b0}};
      sum_r     <= 8'd0;
      len_r     <= {(ADDR_W+1){1'b0}};
      to_cnt_r  <= {TO_W{1'b0}};
    end else begin
      mem_we    <= mem_we_s;
      mem_addr  <= mem_addr_s;
      mem_wdata <= mem_wdata_s;
      cpu_hold  <= cpu_hold_s;
      done      <= done_s;
      err       <= err_s;
      err_code  <= err_code_n_s;
      byte_cnt  <= byte_cnt_s;
      sum_r     <= sum_s;
      len_r     <= len_s;
      to_cnt_r  <= to_cnt_s;
    end
  end

endmodule

// File: doc/ins_loader.md
# ins_loader

Downstream consumer of the UART receive path in the 8-bit CPU. It takes received bytes and framing-error flags and recognises a framed program packet: sync byte, length, payload, checksum. It writes the payload sequentially into the 32×8 instruction memory and holds the CPU in reset while a load session is in progress. It reports completion or a coded error.

## Interface
Parameters:
- DEPTH, 32: instruction-memory depth in bytes; maximum payload length.
- ADDR_W, 5: memory address width, equal to log2(DEPTH).
- SYNC_BYTE, 8'hA5: packet start marker.
- TIMEOUT_CYC, 520600: maximum idle gap between bytes once inside a packet, in Clk cycles (20 byte times at 2603 clk/bit ×10 bits).

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- Load  in  1  load-session enable (level); the same switch that gates the receiver.
- rx_data  in  8  received byte; valid only when rx_valid=1.
- rx_valid  in  1  one-cycle strobe per received byte.
- rx_fe  in  1  framing-error strobe from the receiver.
- mem_we  out  1  instruction-memory write strobe, one cycle per payload byte.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  8  write data.
- cpu_hold  out  1  keeps the CPU in reset.
- done  out  1  sticky: packet accepted.
- err  out  1  sticky: packet rejected.
- err_code  out  2  error reason: 00 framing, 01 bad length, 10 checksum, 11 timeout. Valid only when err=1.
- byte_cnt  out  ADDR_W+1  number of payload bytes written in the current session.

## Operation
- States:
  - IDLE → HUNT on a rising edge of Load.
  - HUNT → LEN on an rx_valid carrying SYNC_BYTE. Any other byte is ignored. No timeout in HUNT.
  - LEN: a byte of 0 or greater than DEPTH → ERR(01). Otherwise latch len and go to DATA.
  - DATA: each byte is written at mem_addr = byte_cnt; byte_cnt increments and the byte is added to sum. After len bytes → CHK.
  - CHK: if the byte equals sum[7:0] → DONE, else → ERR(10).
  - DONE and ERR hold until Load falls, then go to IDLE.
- Load=0 in any state forces IDLE on the next clock. A packet in progress is abandoned; already-written bytes are not rolled back.
- rx_fe=1 in LEN, DATA or CHK → ERR(00). rx_fe=1 in HUNT is ignored.
- rx_fe and rx_valid in the same cycle: rx_fe wins and the byte is discarded.
- Timeout: a counter runs in LEN, DATA and CHK and is cleared on every rx_valid. Reaching TIMEOUT_CYC-1 → ERR(11).
- Checksum: sum is an 8-bit modulo-256 sum of payload bytes only. It is cleared on entry to LEN.
- done and err are cleared on the Load rising edge that starts a new session. Otherwise they persist, including through IDLE.
- cpu_hold = 1 whenever state ∈ {HUNT, LEN, DATA, CHK, ERR}; 0 in IDLE and DONE.

## Timing
- Reset values: state IDLE, mem_we 0, mem_addr 0, mem_wdata 0, cpu_hold 0, done 0, err 0, err_code 00, byte_cnt 0, sum 0, timeout counter 0.
- All outputs are registered.
- mem_we/mem_addr/mem_wdata appear one cycle after the accepting rx_valid. mem_we is high for exactly one cycle.
- State, done and err update one cycle after the deciding strobe.
- Load edge detection costs one cycle, so HUNT is entered two cycles after Load rises.
- byte_cnt saturates at DEPTH; the length check guarantees it never exceeds len.
- rx_valid is assumed to be separated by at least 2 cycles (it is really ≥26000 apart). No back-pressure is provided.

## Structure
- Package loader_pkg holds:
  - the state enum (IDLE, HUNT, LEN, DATA, CHK, DONE, ERR);
  - the err_code constants ERR_FE, ERR_LEN, ERR_CHK, ERR_TO;
  - the default SYNC_BYTE.
- Load rising-edge detection uses the existing posedge_detection module; no new sub-module.
- The timeout counter is inline, with width $clog2(TIMEOUT_CYC).

## Test plan
- Good packet: Load↑, bytes A5 03 11 22 33 66 → writes 11@0, 22@1, 33@2; done=1, err=0, byte_cnt=3, cpu_hold=0.
- Noise before sync: bytes 00 FF A5 01 7E 7E → exactly one write (7E@0); done=1.
- Bad checksum: A5 02 01 02 04 → two writes, then err=1, err_code=10, cpu_hold=1.
- Bad length: A5 00 → err_code=01, no mem_we. Repeat with A5 21 → err_code=01.
- Timeout: A5 02 10, then silence for TIMEOUT_CYC → err_code=11 with one write done. Reset mid-DATA → all outputs at reset values immediately.
- Framing error: A5 02 10, then rx_fe coincident with rx_valid → err_code=00 with no second write. Load↓ then Load↑ → err clears and state is HUNT.
